// File: rtl/dmem_pkg.sv
// Shared types, constants and helpers for the data-memory responder.
// The LFSR constants are only used when DMEM_RESP_RAND_DELAY_EN is defined.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Wide enough for LATENCY (<=15) plus up to 7 random extra cycles
  localparam int CNT_W = 5;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } dmem_req_t;

  // True when the mask shifted to the byte offset stays inside the word
  function automatic logic lane_shift_ok(input logic [3:0] mask, input logic [1:0] off);
    logic [6:0] shifted;
    shifted = 7'(mask) << off;
    return (shifted[6:4] == 3'b000);
  endfunction

  function automatic logic mask_legal(input logic [3:0] mask);
    return (mask == MASK_B) || (mask == MASK_H) || (mask == MASK_W);
  endfunction

endpackage

// File: rtl/dmem_lfsr.sv
// 16-bit Fibonacci LFSR that advances on every enabled cycle.
// Only instantiated when DMEM_RESP_RAND_DELAY_EN is defined.
module dmem_lfsr
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait, masked store or word load.
// Define DMEM_RESP_RAND_DELAY_EN to add 0..7 LFSR-driven extra wait cycles per request.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output dmem_state_e dbg_state
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'(DEPTH) << 2);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // req_ready and resp_valid depend on state only; resp payload is frozen while in RESP.

  dmem_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, load_cnt;
  logic             enter_resp;
  dmem_req_t        lat_req, in_req, acc_req;

  logic [1:0]       off;
  logic [31:0]      rel;
  logic [AW-1:0]    idx;
  logic             in_range;
  logic [3:0]       smask;
  logic [31:0]      sdata;
  logic             acc_err;

  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [3:0]       wr_mask;
  logic [31:0]      wr_data;

  logic [31:0]      mem [DEPTH];

`ifdef DMEM_RESP_RAND_DELAY_EN
  logic [15:0] lfsr_q;

  dmem_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .q     (lfsr_q)
  );

  assign load_cnt = CNT_W'(LATENCY) + CNT_W'(3'(lfsr_q));
`else
  assign load_cnt = CNT_W'(LATENCY);
`endif

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign dbg_state  = state;

  always_comb begin
    in_req       = '0;
    in_req.addr  = req_addr;
    in_req.wen   = req_wen;
    in_req.wdata = req_wdata;
    in_req.wmask = req_wmask;
  end

  // With zero wait the commit edge is the accept edge, so decode the live request there
  assign acc_req = (state == S_IDLE) ? in_req : lat_req;

  always_comb begin
    off      = acc_req.addr[1:0];
    rel      = acc_req.addr - BASE;
    idx      = AW'(rel >> 2);
    in_range = ({1'b0, acc_req.addr} >= {1'b0, BASE}) && ({1'b0, acc_req.addr} < LIMIT);
    smask    = acc_req.wmask << off;
    sdata    = acc_req.wdata << {off, 3'b000};
    acc_err  = !in_range ||
               (acc_req.wen && (!mask_legal(acc_req.wmask) || !lane_shift_ok(acc_req.wmask, off)));
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    enter_resp = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          cnt_n = load_cnt;
          if (load_cnt == '0) begin
            state_n    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_n    = S_RESP;
          enter_resp = 1'b1;
          cnt_n      = '0;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_req    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      wr_en      <= 1'b0;
      wr_idx     <= '0;
      wr_mask    <= '0;
      wr_data    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      wr_en <= enter_resp && acc_req.wen && !acc_err;
      if (state == S_IDLE && req_valid) begin
        lat_req <= in_req;
      end
      if (enter_resp) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || acc_req.wen) ? '0 : mem[idx];
        wr_idx     <= idx;
        wr_mask    <= smask;
        wr_data    <= sdata;
      end
    end
  end

  // Store lanes land one edge after the commit so the array needs no reset path;
  // the next access cannot reach its commit edge sooner than two edges later.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule
